// File: rtl/cbuf_acq_sequencer.sv
// rtl/cbuf_acq_sequencer.sv - CBUF fill sequencer driving the ADC data mux and DDR3 write FIFO
//
// Sequences one fill: fill header, waveform header, num_bursts data bursts, checksum.
//
// Ports:
//   clk, rst_n           acquisition clock, asynchronous active-low reset
//   acq_enable           arms the sequencer (a running fill always completes)
//   acq_trig             single-cycle fill trigger
//   num_bursts           data bursts per fill, latched on an accepted trigger
//   dat_valid            ADC words at the mux are valid this cycle
//   fifo_afull           DDR3 write FIFO almost full; blocks new selects
//   clear_flags          clears trig_overrun / timeout_err (a same-cycle set wins)
//   select_*             one-hot mux selects (issue strobes)
//   checksum_update      fold the data word into the checksum
//   fifo_wr_en           FIFO write, one cycle after each select (mux output is registered)
//   acq_busy             trigger acceptance through the final write cycle
//   acq_done             pulse with the checksum select
//   burst_cnt            bursts issued in the current / last fill
//   trig_overrun         sticky: trigger while busy or disarmed
//   timeout_err          sticky: fill aborted on data stall timeout

module cbuf_acq_sequencer #(
  parameter int BURST_W        = 14,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acq_enable,
  input  logic               acq_trig,
  input  logic [BURST_W-1:0] num_bursts,
  input  logic               dat_valid,
  input  logic               fifo_afull,
  input  logic               clear_flags,
  output logic               select_fill_hdr,
  output logic               select_waveform_hdr,
  output logic               select_dat,
  output logic               select_checksum,
  output logic               checksum_update,
  output logic               fifo_wr_en,
  output logic               acq_busy,
  output logic               acq_done,
  output logic [BURST_W-1:0] burst_cnt,
  output logic               trig_overrun,
  output logic               timeout_err
);

  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FHDR,
    S_WHDR,
    S_DATA,
    S_CKSUM,
    S_FLUSH
  } state_t;

  state_t             state;
  logic [BURST_W-1:0] num_lat;
  logic [STALL_W-1:0] stall_cnt;

  logic dat_issue;
  logic last_burst;
  logic stall_expired;
  logic trig_bad;
  logic timeout_set;

  // Selects depend on this cycle's fifo_afull / dat_valid so that no select is
  // ever issued while the FIFO is almost full; state decode keeps them one-hot.
  assign dat_issue           = (state == S_DATA) && dat_valid && !fifo_afull;
  assign select_fill_hdr     = (state == S_FHDR) && !fifo_afull;
  assign select_waveform_hdr = (state == S_WHDR) && !fifo_afull;
  assign select_dat          = dat_issue;
  assign select_checksum     = (state == S_CKSUM) && !fifo_afull;
  assign checksum_update     = dat_issue;
  assign acq_done            = select_checksum;
  assign acq_busy            = (state != S_IDLE);

  assign last_burst    = (burst_cnt + BURST_W'(1)) == num_lat;
  // Count reaching TIMEOUT_CYCLES-1 on a further stalled cycle means
  // TIMEOUT_CYCLES consecutive stalls have now elapsed.
  assign stall_expired = (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
  assign trig_bad      = acq_trig && ((state != S_IDLE) || !acq_enable);
  assign timeout_set   = (state == S_DATA) && !dat_issue && stall_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      num_lat      <= '0;
      stall_cnt    <= '0;
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      trig_overrun <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      fifo_wr_en   <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;
      // Set has priority over clear
      trig_overrun <= trig_bad    | (trig_overrun & ~clear_flags);
      timeout_err  <= timeout_set | (timeout_err  & ~clear_flags);

      case (state)
        S_IDLE: begin
          if (acq_trig && acq_enable) begin
            num_lat   <= num_bursts;
            burst_cnt <= '0;
            stall_cnt <= '0;
            state     <= S_FHDR;
          end
        end
        S_FHDR: begin
          if (!fifo_afull) state <= S_WHDR;
        end
        S_WHDR: begin
          if (!fifo_afull) state <= (num_lat == '0) ? S_CKSUM : S_DATA;
        end
        S_DATA: begin
          if (dat_issue) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
            stall_cnt <= '0;
            if (last_burst) state <= S_CKSUM;
          end else if (stall_expired) begin
            // Abort with a partial count; the checksum still frames the fill
            state <= S_CKSUM;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        S_CKSUM: begin
          if (!fifo_afull) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Lets the checksum's delayed fifo_wr_en go out while still busy
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbuf_acq_sequencer.sv
// tb/tb_cbuf_acq_sequencer.sv - directed self-checking bench for cbuf_acq_sequencer

module tb_cbuf_acq_sequencer;

  localparam int BW = 14;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acq_enable, acq_trig, dat_valid, fifo_afull, clear_flags;
  logic [BW-1:0] num_bursts;
  logic          select_fill_hdr, select_waveform_hdr, select_dat, select_checksum;
  logic          checksum_update, fifo_wr_en, acq_busy, acq_done;
  logic [BW-1:0] burst_cnt;
  logic          trig_overrun, timeout_err;

  cbuf_acq_sequencer #(.BURST_W(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .acq_enable          (acq_enable),
    .acq_trig            (acq_trig),
    .num_bursts          (num_bursts),
    .dat_valid           (dat_valid),
    .fifo_afull          (fifo_afull),
    .clear_flags         (clear_flags),
    .select_fill_hdr     (select_fill_hdr),
    .select_waveform_hdr (select_waveform_hdr),
    .select_dat          (select_dat),
    .select_checksum     (select_checksum),
    .checksum_update     (checksum_update),
    .fifo_wr_en          (fifo_wr_en),
    .acq_busy            (acq_busy),
    .acq_done            (acq_done),
    .burst_cnt           (burst_cnt),
    .trig_overrun        (trig_overrun),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  logic [3:0] sel;
  assign sel = {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum};

  int checks = 0;
  int errors = 0;

  // Running event counters, sampled mid-cycle
  int n_dat = 0, n_cku = 0, n_wr = 0, n_done = 0;
  int n_multi = 0, n_afull_sel = 0, n_cku_bad = 0;

  always @(negedge clk) begin
    n_dat  <= n_dat  + int'(select_dat);
    n_cku  <= n_cku  + int'(checksum_update);
    n_wr   <= n_wr   + int'(fifo_wr_en);
    n_done <= n_done + int'(acq_done);
    if ($countones(sel) > 1)          n_multi     <= n_multi + 1;
    if (fifo_afull && (sel != 4'd0))  n_afull_sel <= n_afull_sel + 1;
    if (checksum_update && !select_dat) n_cku_bad <= n_cku_bad + 1;
  end

  int s_dat, s_cku, s_wr, s_done, s_afull;

  // FHDR-cycle-onward expectations for a 4-burst, no-stall fill
  logic [3:0] exp_sel  [9] = '{4'h8, 4'h4, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h0, 4'h0};
  logic       exp_wr   [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic       exp_busy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic       exp_done [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    acq_trig = 1'b1;
    cyc();
    acq_trig = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!acq_busy) break;
      cyc();
    end
    check("idle_reached", {31'd0, acq_busy}, 32'd0);
  endtask

  task automatic snap();
    s_dat = n_dat; s_cku = n_cku; s_wr = n_wr; s_done = n_done; s_afull = n_afull_sel;
  endtask

  initial begin
    rst_n = 1'b0; acq_enable = 1'b1; acq_trig = 1'b0; dat_valid = 1'b1;
    fifo_afull = 1'b0; clear_flags = 1'b0; num_bursts = '0;
    #3;
    check("rst_sel",      {28'd0, sel}, 32'd0);
    check("rst_busy",     {31'd0, acq_busy}, 32'd0);
    check("rst_wr",       {31'd0, fifo_wr_en}, 32'd0);
    check("rst_burst",    {18'd0, burst_cnt}, 32'd0);
    check("rst_flags",    {30'd0, trig_overrun, timeout_err}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Full 4-burst fill, cycle by cycle
    num_bursts = 14'd4;
    snap();
    pulse_trig();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("f4_sel[%0d]", i),  {28'd0, sel}, {28'd0, exp_sel[i]});
      check($sformatf("f4_wr[%0d]", i),   {31'd0, fifo_wr_en}, {31'd0, exp_wr[i]});
      check($sformatf("f4_busy[%0d]", i), {31'd0, acq_busy}, {31'd0, exp_busy[i]});
      check($sformatf("f4_done[%0d]", i), {31'd0, acq_done}, {31'd0, exp_done[i]});
      cyc();
    end
    check("f4_cku",   n_cku - s_cku, 32'd4);
    check("f4_wrs",   n_wr - s_wr, 32'd7);
    check("f4_burst", {18'd0, burst_cnt}, 32'd4);

    // Zero-burst fill
    num_bursts = 14'd0;
    snap();
    pulse_trig();
    wait_idle();
    cyc();
    check("f0_dat",   n_dat - s_dat, 32'd0);
    check("f0_cku",   n_cku - s_cku, 32'd0);
    check("f0_wrs",   n_wr - s_wr, 32'd3);
    check("f0_done",  n_done - s_done, 32'd1);
    check("f0_burst", {18'd0, burst_cnt}, 32'd0);

    // Back-pressure and valid gaps
    num_bursts = 14'd3;
    snap();
    pulse_trig();                 // now in FHDR
    cyc();                        // WHDR
    cyc();                        // DATA, first burst issues here
    cyc();
    fifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    fifo_afull = 1'b0;
    dat_valid  = 1'b0;
    cyc(); cyc();
    dat_valid  = 1'b1;
    wait_idle();
    cyc();
    check("bp_dat",      n_dat - s_dat, 32'd3);
    check("bp_wrs",      n_wr - s_wr, 32'd6);
    check("bp_afull_sel", n_afull_sel - s_afull, 32'd0);
    check("bp_burst",    {18'd0, burst_cnt}, 32'd3);
    check("bp_timeout",  {31'd0, timeout_err}, 32'd0);

    // Timeout after two bursts
    num_bursts = 14'd10;
    snap();
    pulse_trig();                 // FHDR
    cyc();                        // WHDR
    cyc();                        // DATA burst 1
    cyc();                        // DATA burst 2
    cyc();
    dat_valid = 1'b0;             // stall cycle 1
    for (int i = 0; i < TO - 1; i++) cyc();
    @(negedge clk);
    check("to_not_yet",  {31'd0, timeout_err}, 32'd0);
    check("to_no_ck_yet", {31'd0, select_checksum}, 32'd0);
    cyc();                        // CKSUM
    @(negedge clk);
    check("to_err",      {31'd0, timeout_err}, 32'd1);
    check("to_ck",       {31'd0, select_checksum}, 32'd1);
    cyc();
    wait_idle();
    cyc();
    check("to_burst",    {18'd0, burst_cnt}, 32'd2);
    check("to_wrs",      n_wr - s_wr, 32'd5);
    check("to_done",     n_done - s_done, 32'd1);
    dat_valid   = 1'b1;
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    check("to_cleared",  {31'd0, timeout_err}, 32'd0);

    // Trigger overrun during DATA
    num_bursts = 14'd4;
    check("ov_initial",  {31'd0, trig_overrun}, 32'd0);
    snap();
    pulse_trig();                 // FHDR
    cyc();                        // WHDR
    cyc();                        // DATA
    pulse_trig();
    check("ov_busy_set", {31'd0, trig_overrun}, 32'd1);
    wait_idle();
    cyc();
    check("ov_dat",      n_dat - s_dat, 32'd4);
    check("ov_wrs",      n_wr - s_wr, 32'd7);
    check("ov_burst",    {18'd0, burst_cnt}, 32'd4);
    cyc(); cyc();
    check("ov_no_restart", {31'd0, acq_busy}, 32'd0);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    check("ov_cleared",  {31'd0, trig_overrun}, 32'd0);

    // Disarmed trigger, then set-wins-over-clear
    acq_enable = 1'b0;
    pulse_trig();
    check("dis_overrun", {31'd0, trig_overrun}, 32'd1);
    cyc();
    check("dis_idle",    {31'd0, acq_busy}, 32'd0);
    clear_flags = 1'b1;
    acq_trig    = 1'b1;
    cyc();
    acq_trig    = 1'b0;
    clear_flags = 1'b0;
    check("set_wins",    {31'd0, trig_overrun}, 32'd1);
    acq_enable = 1'b1;

    // Asynchronous reset mid-fill, then a clean fill
    pulse_trig();                 // FHDR
    cyc();                        // WHDR
    cyc();                        // DATA
    rst_n = 1'b0;
    #1;
    check("ar_sel",      {28'd0, sel}, 32'd0);
    check("ar_wr",       {31'd0, fifo_wr_en}, 32'd0);
    check("ar_busy",     {31'd0, acq_busy}, 32'd0);
    check("ar_burst",    {18'd0, burst_cnt}, 32'd0);
    check("ar_flags",    {30'd0, trig_overrun, timeout_err}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    snap();
    pulse_trig();
    wait_idle();
    cyc();
    check("ar2_dat",     n_dat - s_dat, 32'd4);
    check("ar2_wrs",     n_wr - s_wr, 32'd7);
    check("ar2_done",    n_done - s_done, 32'd1);
    check("ar2_burst",   {18'd0, burst_cnt}, 32'd4);

    check("onehot_sel",  n_multi, 32'd0);
    check("cku_only_dat", n_cku_bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbuf_acq_sequencer.md
Name: cbuf_acq_sequencer

Overview:
Sequences one circular-buffer (CBUF) fill through the ADC data mux: fill header, waveform header, N data bursts, then checksum. It drives the mux select and checksum_update strobes and the DDR3 write-FIFO write enable. It sits between the trigger/acquisition control logic and the mux/FIFO. It handles FIFO back-pressure, data-valid gaps, timeouts and triggers that arrive while busy.

Parameters:
BURST_W, 14, width of the burst count (matches the async_num_bursts register width)
TIMEOUT_CYCLES, 65535, number of consecutive stalled DATA cycles before the fill is aborted to the checksum

Ports:
clk  in  1  acquisition clock (same clock as the mux)
rst_n  in  1  asynchronous active-low reset
acq_enable  in  1  arms the sequencer; low forces a return to IDLE after the current fill completes
acq_trig  in  1  single-cycle trigger that starts a fill
num_bursts  in  BURST_W  number of 8-sample bursts per fill; latched on an accepted trigger
dat_valid  in  1  the ADC pair words presented to the mux are valid this cycle
fifo_afull  in  1  DDR3 write FIFO almost-full; no new select is issued while high
clear_flags  in  1  clears the sticky flags
select_fill_hdr  out  1  mux select: fill header
select_waveform_hdr  out  1  mux select: waveform header
select_dat  out  1  mux select: data
select_checksum  out  1  mux select: checksum
checksum_update  out  1  XOR data into the checksum
fifo_wr_en  out  1  FIFO write strobe, aligned to the registered mux output
acq_busy  out  1  high from trigger acceptance through the cycle of the last write
acq_done  out  1  one-cycle pulse when the checksum write is issued
burst_cnt  out  BURST_W  number of data bursts issued in the current or last fill
trig_overrun  out  1  sticky: a trigger arrived while busy or disarmed
timeout_err  out  1  sticky: the fill was aborted by timeout

Behaviour:
- Reset (asynchronous, rst_n=0): state is IDLE; all outputs are 0; burst_cnt=0; latched count=0; stall counter=0.
- Select outputs are mutually exclusive; at most one is high per cycle.
- An issue cycle is any cycle with a select high. fifo_wr_en is the OR of all selects delayed by one clk, because the mux registers its output.
- States:
  - IDLE: when acq_trig && acq_enable, latch num_bursts, clear burst_cnt and the stall counter, and go to FHDR. acq_busy goes high on the next edge.
  - FHDR: if !fifo_afull, assert select_fill_hdr for one cycle and go to WHDR; otherwise hold with all selects low.
  - WHDR: if !fifo_afull, assert select_waveform_hdr for one cycle. Go to DATA, or to CKSUM when the latched count is 0.
  - DATA: an issue happens when dat_valid && !fifo_afull. On each issue, assert select_dat and checksum_update in the same cycle and increment burst_cnt. When burst_cnt reaches the latched count, go to CKSUM. Non-issue cycles have all selects low.
  - CKSUM: always one or more cycles after the last checksum_update, so the checksum register is final. If !fifo_afull, assert select_checksum and acq_done for one cycle and go to FLUSH.
  - FLUSH: one cycle so the final fifo_wr_en is issued. acq_busy drops at the end of this cycle. Then go to IDLE.
- Stall counter: counts consecutive non-issue DATA cycles and resets on each issue. When it equals TIMEOUT_CYCLES, set timeout_err and go to CKSUM with a partial burst_cnt. A checksum is always written, so the fill stays framed.
- checksum_update is never asserted outside DATA issue cycles.
- Trigger while not IDLE, or acq_trig while acq_enable=0: the trigger is ignored and trig_overrun is set.
- Simultaneous trigger and FLUSH: the trigger is ignored and counted as an overrun. No back-to-back fill starts without passing through IDLE.
- clear_flags clears trig_overrun and timeout_err. If a set event occurs in the same cycle, the set wins.
- acq_enable falling mid-fill does not abort; the fill runs to CKSUM.
- rst_n asserted mid-fill returns to IDLE immediately with no checksum. The downstream logic discards the partial fill.
- burst_cnt holds its final value in IDLE until the next accepted trigger.

Test Plan:
- num_bursts=4, dat_valid=1, fifo_afull=0, single trigger -> selects FHDR, WHDR, DAT×4, CKSUM on consecutive cycles; checksum_update on exactly 4 cycles; fifo_wr_en high for 7 cycles lagging by 1; acq_done one pulse; burst_cnt=4.
- num_bursts=0 -> FHDR, WHDR, CKSUM; checksum_update is never asserted; 3 FIFO writes.
- num_bursts=3, fifo_afull high for 5 cycles after the first data burst and dat_valid low for 2 cycles later -> exactly 3 select_dat pulses; no select is issued while afull is high; total writes=6.
- TIMEOUT_CYCLES=8, num_bursts=10, dat_valid stuck low after 2 bursts -> after 8 stalled cycles timeout_err=1, the checksum is issued, burst_cnt=2; clear_flags then drops timeout_err.
- A second acq_trig during DATA, and a trigger with acq_enable=0 -> trig_overrun=1; the running fill completes unaltered; no new fill starts.
- rst_n pulsed low during DATA -> all outputs 0 asynchronously; the next trigger produces a clean full sequence.
